// File: rtl/dist_sched_pkg.sv
// Shared definitions for the distribution scheduler and the crossbar it feeds.
// Holds the parameter defaults and the scheduler FSM state encoding so that
// the crossbar and scheduler agree on bus widths and state values.
package dist_sched_pkg;

  localparam int DS_DATA_TYPE  = 16;
  localparam int DS_NUM_PES    = 64;
  localparam int DS_INPUT_BW   = 64;
  localparam int DS_LOG2_PES   = 6;
  localparam int DS_FIFO_DEPTH = 4;
  localparam int DS_REP_W      = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/dist_fifo.sv
// In-order descriptor FIFO for the distribution scheduler.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write strobe and entry (ignored while full)
//   pop, rdata      read strobe and head entry (rdata is the current head)
//   full, empty     occupancy flags
// Pointers carry one extra MSB so full and empty are told apart when the
// index bits match.
module dist_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dist_sched.sv
// Distribution scheduler: buffers {data, mux, rep} descriptors and replays
// each one rep+1 times onto the crossbar input buses.
// Ports:
//   CLK, rst                     clock, asynchronous active-high reset
//   i_valid/o_ready              descriptor handshake
//   i_data_bus/i_mux_bus/i_rep   descriptor fields (rep = issues minus one)
//   i_stall                      downstream hold, freezes issuing
//   o_data_bus/o_mux_bus         held descriptor driven to the crossbar
//   o_issue                      buses valid this cycle
//   o_dist_valid                 o_issue delayed one cycle
//   o_busy                       descriptors buffered or issue in progress
//
// state    | meaning
// ST_IDLE  | output registers idle; loads the FIFO head when one is present
// ST_ISSUE | output registers hold a descriptor; one issue per unstalled cycle
module dist_sched
  import dist_sched_pkg::*;
#(
  parameter int DATA_TYPE  = DS_DATA_TYPE,
  parameter int NUM_PES    = DS_NUM_PES,
  parameter int INPUT_BW   = DS_INPUT_BW,
  parameter int LOG2_PES   = DS_LOG2_PES,
  parameter int FIFO_DEPTH = DS_FIFO_DEPTH,
  parameter int REP_W      = DS_REP_W
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus,
  input  logic [LOG2_PES*NUM_PES-1:0]   i_mux_bus,
  input  logic [REP_W-1:0]              i_rep,
  input  logic                          i_stall,
  output logic [INPUT_BW*DATA_TYPE-1:0] o_data_bus,
  output logic [LOG2_PES*NUM_PES-1:0]   o_mux_bus,
  output logic                          o_issue,
  output logic                          o_dist_valid,
  output logic                          o_busy
);

  localparam int DW = INPUT_BW * DATA_TYPE;
  localparam int MW = LOG2_PES * NUM_PES;
  localparam int EW = DW + MW + REP_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             load;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;
  logic [DW-1:0]    head_data;
  logic [MW-1:0]    head_mux;
  logic [REP_W-1:0] head_rep;

  logic [0:0]       state_q, state_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [MW-1:0]    mux_q, mux_d;
  logic             dist_valid_q;

  assign push       = i_valid && !fifo_full;
  assign fifo_wdata = {i_data_bus, i_mux_bus, i_rep};
  assign {head_data, head_mux, head_rep} = fifo_rdata;

  dist_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Loading from IDLE ignores i_stall: the stall only holds back issues, so
  // the head is staged into the output registers ahead of the stall release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mux_d   = mux_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_stall) begin
          if (cnt_q == '0) begin
            if (!fifo_empty) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - REP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      cnt_d  = head_rep;
      data_d = head_data;
      mux_d  = head_mux;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      mux_q        <= '0;
      dist_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      mux_q        <= mux_d;
      dist_valid_q <= o_issue;
    end
  end

  assign o_ready      = !fifo_full;
  assign o_issue      = (state_q == ST_ISSUE) && !i_stall;
  assign o_data_bus   = data_q;
  assign o_mux_bus    = mux_q;
  assign o_dist_valid = dist_valid_q;
  assign o_busy       = !fifo_empty || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_dist_sched.sv
module tb_dist_sched;

  localparam int DT = 16;
  localparam int NP = 64;
  localparam int IB = 64;
  localparam int LP = 6;
  localparam int FD = 4;
  localparam int RW = 8;
  localparam int DW = IB * DT;
  localparam int MW = LP * NP;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_stall = 1'b0;
  logic [DW-1:0] i_data_bus = '0;
  logic [MW-1:0] i_mux_bus = '0;
  logic [RW-1:0] i_rep = '0;
  logic          o_ready;
  logic [DW-1:0] o_data_bus;
  logic [MW-1:0] o_mux_bus;
  logic          o_issue;
  logic          o_dist_valid;
  logic          o_busy;

  dist_sched #(
    .DATA_TYPE  (DT),
    .NUM_PES    (NP),
    .INPUT_BW   (IB),
    .LOG2_PES   (LP),
    .FIFO_DEPTH (FD),
    .REP_W      (RW)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data_bus   (i_data_bus),
    .i_mux_bus    (i_mux_bus),
    .i_rep        (i_rep),
    .i_stall      (i_stall),
    .o_data_bus   (o_data_bus),
    .o_mux_bus    (o_mux_bus),
    .o_issue      (o_issue),
    .o_dist_valid (o_dist_valid),
    .o_busy       (o_busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: the expected issue stream is simply every accepted
  // descriptor repeated rep+1 times, in acceptance order.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mux();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < MW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push(input logic [RW-1:0] rep, output logic [DW-1:0] d_out);
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    bit ok;
    d  = rnd_data();
    m  = rnd_mux();
    ok = 1'b0;
    d_out      = d;
    i_valid    = 1'b1;
    i_data_bus = d;
    i_mux_bus  = m;
    i_rep      = rep;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge CLK);
      ok = o_ready;
      @(posedge CLK);
      #1;
    end
    i_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: got no handshake within 60 cycles want accepted");
    end else begin
      for (int k = 0; k <= int'(rep); k++) exp_q.push_back({d, m});
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge CLK);
      ok = !o_busy;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles want idle", budget);
    end
    chk("model_drained", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every issue cycle must match the head of the model stream, and
  // o_dist_valid must be last cycle's o_issue.
  logic prev_issue = 1'b0;
  logic prev_ok = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!rst && prev_ok) chk("dist_valid", 32'(o_dist_valid), 32'(prev_issue));
    if (!rst && o_issue) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got o_issue=1 with no expected issue want o_issue=0");
      end else begin
        e = exp_q.pop_front();
        chkw("issue_data", o_data_bus, e.d);
        chkw("issue_mux", DW'(o_mux_bus), DW'(e.m));
      end
    end
    prev_issue <= o_issue;
    prev_ok    <= !rst;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] dsave;
    logic [DW-1:0] dummy;
    int n;
    int run;
    int maxrun;
    bit stalled;

    rst = 1'b1;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_issue", 32'(o_issue), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_dist_valid", 32'(o_dist_valid), 0);
    chkw("rst_data", o_data_bus, '0);
    chkw("rst_mux", DW'(o_mux_bus), '0);
    @(posedge CLK);
    #1;

    // Single rep=0 descriptor: issue lands two cycles after the handshake.
    push(8'd0, d0);
    @(negedge CLK);
    chk("lat_c1_issue", 32'(o_issue), 0);
    @(negedge CLK);
    chk("lat_c2_issue", 32'(o_issue), 1);
    chkw("lat_c2_data", o_data_bus, d0);
    @(negedge CLK);
    chk("lat_c3_issue", 32'(o_issue), 0);
    chk("lat_c3_dist_valid", 32'(o_dist_valid), 1);
    @(negedge CLK);
    chk("lat_c4_dist_valid", 32'(o_dist_valid), 0);
    @(posedge CLK);
    #1;
    wait_idle(10);

    // A(rep=2) then B(rep=1) back to back: five consecutive issues.
    push(8'd2, d0);
    push(8'd1, dummy);
    n = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (o_issue) begin
        n++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("b2b_total", n, 5);
    chk("b2b_run", maxrun, 5);
    @(posedge CLK);
    #1;
    wait_idle(10);

    // Five pushes under stall: head staged, four buffered, then full.
    i_stall = 1'b1;
    push(8'($urandom_range(0, 2)), d0);
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 2)), dummy);
    @(negedge CLK);
    chk("stall_full_ready", 32'(o_ready), 0);
    chkw("stall_head_data", o_data_bus, d0);
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (o_issue) n++;
    end
    chk("stall_no_issue", n, 0);
    chk("stall_still_full", 32'(o_ready), 0);
    @(posedge CLK);
    #1 i_stall = 1'b0;
    wait_idle(100);

    // Three-cycle stall in the middle of a rep=4 descriptor.
    push(8'd4, d0);
    n = 0;
    stalled = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (o_issue) n++;
      if (!stalled && n == 2) begin
        stalled = 1'b1;
        dsave = o_data_bus;
        @(posedge CLK);
        #1 i_stall = 1'b1;
        repeat (3) begin
          @(negedge CLK);
          chk("mid_stall_issue", 32'(o_issue), 0);
          chkw("mid_stall_data", o_data_bus, dsave);
        end
        @(posedge CLK);
        #1 i_stall = 1'b0;
      end
    end
    chk("mid_stall_total", n, 5);
    @(posedge CLK);
    #1;
    wait_idle(10);

    // Largest repeat count.
    push(8'd255, d0);
    n = 0;
    for (int c = 0; c < 270; c++) begin
      @(negedge CLK);
      if (o_issue) n++;
    end
    chk("rep255_total", n, 256);
    @(posedge CLK);
    #1;
    wait_idle(10);

    // Reset in the second issue cycle of a rep=9 descriptor with two queued.
    push(8'd9, d0);
    push(8'($urandom_range(0, 3)), dummy);
    push(8'($urandom_range(0, 3)), dummy);
    chk("pre_rst_issue", 32'(o_issue), 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_issue", 32'(o_issue), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_ready", 32'(o_ready), 1);
    chk("mid_rst_dist_valid", 32'(o_dist_valid), 0);
    chkw("mid_rst_data", o_data_bus, '0);
    chkw("mid_rst_mux", DW'(o_mux_bus), '0);
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (o_issue) n++;
    end
    chk("post_rst_issue", n, 0);
    chk("post_rst_busy", 32'(o_busy), 0);
    @(posedge CLK);
    #1;

    // Random stall traffic: rep=0 across pointer wrap, then mixed reps.
    for (int ph = 0; ph < 2; ph++) begin
      fork
        begin
          for (int i = 0; i < 12; i++) begin
            logic [DW-1:0] dd;
            push((ph == 0) ? 8'd0 : 8'($urandom_range(0, 3)), dd);
            repeat ($urandom_range(0, 2)) begin
              @(posedge CLK);
              #1;
            end
          end
        end
        begin
          repeat (120) begin
            @(posedge CLK);
            #1 i_stall = ($urandom_range(0, 2) == 0);
          end
          i_stall = 1'b0;
        end
      join
      i_stall = 1'b0;
      wait_idle(300);
    end

    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
